// File: rtl/imem_if.sv
// Instruction memory request/ready channel.
// The fetch stage is the master; the memory is the slave.
interface imem_if;
  logic        req;
  logic [63:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, talks to instruction memory,
// and holds the IF/ID pipeline register.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] PC_INC   = 64'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  imem_if.master      imem,
  output logic [31:0] instruction,
  output logic [63:0] PC_out_IF_ID,
  output logic [63:0] PC_inc_IF_ID,
  output logic        valid_IF_ID
);

  typedef enum logic [1:0] {
    FETCH,
    DISCARD,
    HOLD
  } state_t;

  state_t      state, state_nx;
  logic [63:0] pc, pc_nx;
  logic [63:0] pend, pend_nx;
  logic [63:0] hold_pc, hold_pc_nx;
  logic [31:0] hold_ins, hold_ins_nx;
  logic [31:0] ins_nx;
  logic [63:0] pco_nx, pci_nx;
  logic        vld_nx;
  logic        bub;
  logic        done;
  logic [63:0] pc_inc;

  // Request drops the instant reset asserts.
  assign imem.req  = !reset && (state != HOLD);
  assign imem.addr = pc;
  assign done      = imem.req && imem.ready;
  assign pc_inc    = pc + PC_INC;

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    pend_nx     = pend;
    hold_pc_nx  = hold_pc;
    hold_ins_nx = hold_ins;
    ins_nx      = instruction;
    pco_nx      = PC_out_IF_ID;
    pci_nx      = PC_inc_IF_ID;
    vld_nx      = valid_IF_ID;
    bub         = 1'b0;
    unique case (state)
      FETCH: begin
        if (redirect) begin
          bub = 1'b1;
          if (done) begin
            pc_nx = redirect_target;
          end else begin
            pend_nx  = redirect_target;
            state_nx = DISCARD;
          end
        end else if (stall) begin
          if (done) begin
            hold_ins_nx = imem.rdata;
            hold_pc_nx  = pc;
            pc_nx       = pc_inc;
            state_nx    = HOLD;
          end
        end else if (done) begin
          ins_nx = imem.rdata;
          pco_nx = pc;
          pci_nx = pc_inc;
          vld_nx = 1'b1;
          pc_nx  = pc_inc;
        end else begin
          bub = 1'b1;
        end
      end
      DISCARD: begin
        if (redirect)
          pend_nx = redirect_target;
        // Newest redirect wins if it lands on the completing edge.
        if (done) begin
          pc_nx    = redirect ? redirect_target : pend;
          state_nx = FETCH;
        end
        if (redirect || !stall)
          bub = 1'b1;
      end
      HOLD: begin
        if (redirect) begin
          bub      = 1'b1;
          pc_nx    = redirect_target;
          state_nx = FETCH;
        end else if (!stall) begin
          ins_nx   = hold_ins;
          pco_nx   = hold_pc;
          pci_nx   = hold_pc + PC_INC;
          vld_nx   = 1'b1;
          state_nx = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase
    if (bub) begin
      ins_nx = 32'h0;
      pco_nx = 64'h0;
      pci_nx = 64'h0;
      vld_nx = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      pend         <= 64'h0;
      hold_pc      <= 64'h0;
      hold_ins     <= 32'h0;
      instruction  <= 32'h0;
      PC_out_IF_ID <= 64'h0;
      PC_inc_IF_ID <= 64'h0;
      valid_IF_ID  <= 1'b0;
    end else begin
      state        <= state_nx;
      pc           <= pc_nx;
      pend         <= pend_nx;
      hold_pc      <= hold_pc_nx;
      hold_ins     <= hold_ins_nx;
      instruction  <= ins_nx;
      PC_out_IF_ID <= pco_nx;
      PC_inc_IF_ID <= pci_nx;
      valid_IF_ID  <= vld_nx;
    end
  end

endmodule
